// File: rtl/spiflash_responder_pkg.sv
// Shared opcodes, FSM state encoding and pin-event payload for the SPI-flash responder.
// Optional RDID support is enabled with SPIF_RDID_EN.
package spiflash_responder_pkg;

    localparam logic [7:0] OP_WREN   = 8'h06;
    localparam logic [7:0] OP_WRDI   = 8'h04;
    localparam logic [7:0] OP_RDSR   = 8'h05;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_PP     = 8'h02;
    localparam logic [7:0] OP_CE     = 8'hC7;
    localparam logic [7:0] OP_CE_ALT = 8'h60;
    localparam logic [7:0] OP_RDID   = 8'h9F;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_BITS = 24;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // Synchronised pin levels and single-cycle edge pulses
    typedef struct packed {
        logic clk_rise;
        logic clk_fall;
        logic cs_rise;
        logic cs_fall;
        logic cs_high;
        logic mosi;
    } pin_evt_t;

    // Opcodes that complete in one byte and commit at CS rise
    function automatic logic is_single_op(input logic [7:0] op);
        return (op == OP_WREN) || (op == OP_WRDI) || (op == OP_CE) || (op == OP_CE_ALT);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulses for the SPI clock and chip select.
module spi_pin_sync
    import spiflash_responder_pkg::*;
(
    input  logic     sclk,
    input  logic     rst_n,
    input  logic     flash_clk,
    input  logic     flash_cs,
    input  logic     flash_mosi,
    output pin_evt_t evt_c
);

    logic [1:0] clk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       clk_prev;
    logic       cs_prev;

    // CS resets to its idle (high) level so no edge is seen leaving reset with the bus idle
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            clk_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            clk_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], flash_clk};
            cs_sync   <= {cs_sync[0], flash_cs};
            mosi_sync <= {mosi_sync[0], flash_mosi};
            clk_prev  <= clk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign evt_c.clk_rise = clk_sync[1] & ~clk_prev;
    assign evt_c.clk_fall = ~clk_sync[1] & clk_prev;
    assign evt_c.cs_rise  = cs_sync[1] & ~cs_prev;
    assign evt_c.cs_fall  = ~cs_sync[1] & cs_prev;
    assign evt_c.cs_high  = cs_sync[1];
    assign evt_c.mosi     = mosi_sync[1];

endmodule

// File: rtl/spiflash_responder.sv
// SPI-flash target: oversampled mode-0 decoder for WREN/WRDI/RDSR/READ/PP/CE driving a byte memory port.
// Define SPIF_RDID_EN to add the 9F (RDID) JEDEC ID response.
module spiflash_responder
    import spiflash_responder_pkg::*;
#(
    parameter int unsigned AW           = 16,
    parameter int unsigned ERASE_CYCLES = 1000,
    parameter int unsigned PROG_CYCLES  = 50
`ifdef SPIF_RDID_EN
    ,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4015
`endif
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          flash_clk,
    input  logic          flash_cs,
    input  logic          flash_mosi,
    output logic          flash_miso,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    output logic          erase_start,
    output logic          wip,
    output logic          wel
);

    localparam int unsigned BUSY_MAX = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int unsigned BW       = $clog2(BUSY_MAX + 1);

    pin_evt_t evt_c;

    spi_pin_sync u_pin_sync (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .flash_clk  (flash_clk),
        .flash_cs   (flash_cs),
        .flash_mosi (flash_mosi),
        .evt_c      (evt_c)
    );

    state_t               state, state_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [ADDR_BITS-2:0] sh, sh_n;
    logic [BYTE_W-1:0]    tx, tx_n;
    logic [BYTE_W-1:0]    op, op_n;
    logic                 cmd_done, cmd_done_n;
    logic                 op_ok, op_ok_n;
    logic                 pp_wrote, pp_wrote_n;
    logic                 inc_pend, inc_pend_n;
    logic [BW-1:0]        busy_cnt, busy_cnt_n;
    logic                 flash_miso_n;
    logic [AW-1:0]        mem_addr_n;
    logic                 mem_re_n;
    logic                 mem_we_n;
    logic [7:0]           mem_wdata_n;
    logic                 erase_start_n;
    logic                 wip_n;
    logic                 wel_n;
`ifdef SPIF_RDID_EN
    logic                 id_mode, id_mode_n;
    logic [1:0]           id_idx, id_idx_n;
`endif

    logic [BYTE_W-1:0]    rx_byte_c;
    logic [ADDR_BITS-1:0] addr_c;
    logic [BYTE_W-1:0]    load_byte_c;

    assign rx_byte_c = {sh[6:0], evt_c.mosi};
    assign addr_c    = {sh, evt_c.mosi};

    // Byte presented at the start of each response byte
    always_comb begin
        load_byte_c = {6'b0, wel, wip};
        if (state == ST_RD_DATA) begin
            load_byte_c = mem_rdata;
        end
`ifdef SPIF_RDID_EN
        else if (id_mode) begin
            case (id_idx)
                2'd0:    load_byte_c = JEDEC_ID[23:16];
                2'd1:    load_byte_c = JEDEC_ID[15:8];
                2'd2:    load_byte_c = JEDEC_ID[7:0];
                default: load_byte_c = 8'hFF;
            endcase
        end
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        sh_n          = sh;
        tx_n          = tx;
        op_n          = op;
        cmd_done_n    = cmd_done;
        op_ok_n       = op_ok;
        pp_wrote_n    = pp_wrote;
        inc_pend_n    = 1'b0;
        busy_cnt_n    = busy_cnt;
        flash_miso_n  = flash_miso;
        mem_addr_n    = mem_addr;
        mem_re_n      = 1'b0;
        mem_we_n      = 1'b0;
        mem_wdata_n   = mem_wdata;
        erase_start_n = 1'b0;
        wip_n         = wip;
        wel_n         = wel;
`ifdef SPIF_RDID_EN
        id_mode_n     = id_mode;
        id_idx_n      = id_idx;
`endif

        // Busy timer runs on sclk regardless of bus activity
        if (wip) begin
            busy_cnt_n = busy_cnt - BW'(1);
            if (busy_cnt == BW'(1)) begin
                wip_n = 1'b0;
            end
        end

        // Address advances the cycle after a write strobe so the strobe sees the old address
        if (inc_pend) begin
            mem_addr_n = mem_addr + AW'(1);
        end

        if (evt_c.cs_high) begin
            if (evt_c.cs_rise) begin
                if (state == ST_CMD && cmd_done && op_ok) begin
                    case (op)
                        OP_WREN: wel_n = 1'b1;
                        OP_WRDI: wel_n = 1'b0;
                        OP_CE, OP_CE_ALT: begin
                            if (wel && !wip) begin
                                erase_start_n = 1'b1;
                                wel_n         = 1'b0;
                                wip_n         = 1'b1;
                                busy_cnt_n    = BW'(ERASE_CYCLES);
                            end
                        end
                        default: ;
                    endcase
                end
                if (state == ST_WR_DATA && pp_wrote) begin
                    wel_n      = 1'b0;
                    wip_n      = 1'b1;
                    busy_cnt_n = BW'(PROG_CYCLES);
                end
            end
            state_n      = ST_IDLE;
            bit_cnt_n    = '0;
            flash_miso_n = 1'b1;
            cmd_done_n   = 1'b0;
            op_ok_n      = 1'b0;
            pp_wrote_n   = 1'b0;
`ifdef SPIF_RDID_EN
            id_mode_n    = 1'b0;
            id_idx_n     = 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt_c.cs_fall) begin
                        state_n   = ST_CMD;
                        bit_cnt_n = '0;
                    end
                end

                ST_CMD: begin
                    if (evt_c.clk_rise) begin
                        if (!cmd_done) begin
                            sh_n      = {sh[ADDR_BITS-3:0], evt_c.mosi};
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(7)) begin
                                bit_cnt_n  = '0;
                                cmd_done_n = 1'b1;
                                op_n       = rx_byte_c;
                                if (wip && rx_byte_c != OP_RDSR) begin
                                    state_n = ST_IGNORE;
                                end else if (is_single_op(rx_byte_c)) begin
                                    op_ok_n = 1'b1;
                                end else begin
                                    case (rx_byte_c)
                                        OP_READ: state_n = ST_ADDR;
                                        OP_PP:   state_n = wel ? ST_ADDR : ST_IGNORE;
                                        OP_RDSR: state_n = ST_STATUS;
`ifdef SPIF_RDID_EN
                                        OP_RDID: begin
                                            state_n   = ST_STATUS;
                                            id_mode_n = 1'b1;
                                            id_idx_n  = 2'd0;
                                        end
`else
                                        OP_RDID: state_n = ST_IGNORE;
`endif
                                        default: state_n = ST_IGNORE;
                                    endcase
                                end
                            end
                        end else begin
                            // Any bit beyond a single-byte opcode cancels it
                            op_ok_n = 1'b0;
                        end
                    end
                end

                ST_ADDR: begin
                    if (evt_c.clk_rise) begin
                        sh_n      = {sh[ADDR_BITS-3:0], evt_c.mosi};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                            bit_cnt_n  = '0;
                            mem_addr_n = AW'(addr_c);
                            if (op == OP_READ) begin
                                state_n  = ST_RD_DATA;
                                mem_re_n = 1'b1;
                            end else begin
                                state_n = ST_WR_DATA;
                            end
                        end
                    end
                end

                ST_RD_DATA, ST_STATUS: begin
                    if (evt_c.clk_fall) begin
                        if (bit_cnt == '0) begin
                            flash_miso_n = load_byte_c[7];
                            tx_n         = {load_byte_c[6:0], 1'b1};
                        end else begin
                            flash_miso_n = tx[7];
                            tx_n         = {tx[6:0], 1'b1};
                        end
                    end
                    if (evt_c.clk_rise) begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt_n = '0;
                            if (state == ST_RD_DATA) begin
                                mem_addr_n = mem_addr + AW'(1);
                                mem_re_n   = 1'b1;
                            end
`ifdef SPIF_RDID_EN
                            else if (id_mode && id_idx != 2'd3) begin
                                id_idx_n = id_idx + 2'd1;
                            end
`endif
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (evt_c.clk_rise) begin
                        sh_n      = {sh[ADDR_BITS-3:0], evt_c.mosi};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt_n   = '0;
                            mem_wdata_n = rx_byte_c;
                            mem_we_n    = 1'b1;
                            pp_wrote_n  = 1'b1;
                            inc_pend_n  = 1'b1;
                        end
                    end
                end

                ST_IGNORE: ;

                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            sh          <= '0;
            tx          <= 8'hFF;
            op          <= '0;
            cmd_done    <= 1'b0;
            op_ok       <= 1'b0;
            pp_wrote    <= 1'b0;
            inc_pend    <= 1'b0;
            busy_cnt    <= '0;
            flash_miso  <= 1'b1;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            erase_start <= 1'b0;
            wip         <= 1'b0;
            wel         <= 1'b0;
`ifdef SPIF_RDID_EN
            id_mode     <= 1'b0;
            id_idx      <= 2'd0;
`endif
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            sh          <= sh_n;
            tx          <= tx_n;
            op          <= op_n;
            cmd_done    <= cmd_done_n;
            op_ok       <= op_ok_n;
            pp_wrote    <= pp_wrote_n;
            inc_pend    <= inc_pend_n;
            busy_cnt    <= busy_cnt_n;
            flash_miso  <= flash_miso_n;
            mem_addr    <= mem_addr_n;
            mem_re      <= mem_re_n;
            mem_we      <= mem_we_n;
            mem_wdata   <= mem_wdata_n;
            erase_start <= erase_start_n;
            wip         <= wip_n;
            wel         <= wel_n;
`ifdef SPIF_RDID_EN
            id_mode     <= id_mode_n;
            id_idx      <= id_idx_n;
`endif
        end
    end

endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder: drives mode-0 SPI transactions and models the byte memory.
module tb_spiflash_responder;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        flash_clk;
    logic        flash_cs;
    logic        flash_mosi;
    logic        flash_miso;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        erase_start;
    logic        wip;
    logic        wel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sclk = ~sclk;

    spiflash_responder dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .flash_clk   (flash_clk),
        .flash_cs    (flash_cs),
        .flash_mosi  (flash_mosi),
        .flash_miso  (flash_miso),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .erase_start (erase_start),
        .wip         (wip),
        .wel         (wel)
    );

    // Byte memory model plus strobe logging
    logic [7:0]  mem [0:65535];
    logic [15:0] we_addr [0:7];
    logic [7:0]  we_data [0:7];
    int          we_cnt     = 0;
    int          erase_cnt  = 0;
    int          erase_long = 0;
    logic        erase_prev = 1'b0;

    always @(posedge sclk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            if (we_cnt < 8) begin
                we_addr[we_cnt] = mem_addr;
                we_data[we_cnt] = mem_wdata;
            end
            we_cnt++;
        end
        if (erase_start) begin
            erase_cnt++;
            if (erase_prev) erase_long++;
        end
        erase_prev = erase_start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift nbits MSB-first; MISO is sampled just before each rising edge
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic [7:0] t;
        t  = tx;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            flash_mosi = t[7];
            t = {t[6:0], 1'b0};
            repeat (4) @(negedge sclk);
            rx = {rx[6:0], flash_miso};
            flash_clk = 1'b1;
            repeat (4) @(negedge sclk);
            flash_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge sclk);
        flash_cs = 1'b0;
        repeat (4) @(negedge sclk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge sclk);
        flash_cs = 1'b1;
        repeat (8) @(negedge sclk);
    endtask

    task automatic send_op(input logic [7:0] op);
        logic [7:0] r;
        cs_begin();
        spi_bits(op, 8, r);
        cs_end();
    endtask

    task automatic read_status(output logic [7:0] st);
        logic [7:0] r;
        cs_begin();
        spi_bits(8'h05, 8, r);
        spi_bits(8'hFF, 8, st);
        cs_end();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  st;
        logic [7:0]  r;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [31:0] id_word;
        logic [31:0] id_exp;

        rst_n      = 1'b0;
        flash_clk  = 1'b0;
        flash_cs   = 1'b1;
        flash_mosi = 1'b0;
        repeat (5) @(negedge sclk);
        check("rst_miso", 32'(flash_miso), 32'h1);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_strobes", {29'b0, mem_re, mem_we, erase_start}, 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_status", {30'b0, wel, wip}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge sclk);

        // Chip erase without write enable is refused
        send_op(8'hC7);
        check("ce_nowel_erase", 32'(erase_cnt), 32'd0);
        read_status(st);
        check("ce_nowel_rdsr", 32'(st), 32'h00);

        // Enabled chip erase: single pulse, busy window, WREN ignored while busy
        send_op(8'h06);
        check("wren_wel", 32'(wel), 32'h1);
        send_op(8'hC7);
        check("ce_erase_cnt", 32'(erase_cnt), 32'd1);
        check("ce_erase_width", 32'(erase_long), 32'd0);
        check("ce_status", {30'b0, wel, wip}, 32'h1);
        send_op(8'h06);
        check("busy_wren_ignored", 32'(wel), 32'h0);
        read_status(st);
        check("ce_rdsr_busy", 32'(st), 32'h01);
        repeat (1100) @(negedge sclk);
        check("ce_wip_done", 32'(wip), 32'h0);
        read_status(st);
        check("ce_rdsr_done", 32'(st), 32'h00);

        // Page program of two bytes at 0x0010
        send_op(8'h06);
        cs_begin();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h10, 8, r);
        spi_bits(8'hA5, 8, r);
        spi_bits(8'h5A, 8, r);
        cs_end();
        check("pp_we_cnt", 32'(we_cnt), 32'd2);
        check("pp_addr0", 32'(we_addr[0]), 32'h0010);
        check("pp_data0", 32'(we_data[0]), 32'hA5);
        check("pp_addr1", 32'(we_addr[1]), 32'h0011);
        check("pp_data1", 32'(we_data[1]), 32'h5A);
        check("pp_status", {30'b0, wel, wip}, 32'h1);
        repeat (60) @(negedge sclk);
        check("pp_wip_done", 32'(wip), 32'h0);

        // Page program without write enable writes nothing
        cs_begin();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h20, 8, r);
        spi_bits(8'h77, 8, r);
        cs_end();
        check("pp_nowel_we", 32'(we_cnt), 32'd2);
        check("pp_nowel_wip", 32'(wip), 32'h0);

        // Read across the top of the address space
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        cs_begin();
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'hFF, 8, r);
        spi_bits(8'hFF, 8, r);
        spi_bits(8'hFF, 8, b0);
        spi_bits(8'hFF, 8, b1);
        cs_end();
        check("rd_byte0", 32'(b0), 32'h11);
        check("rd_wrap_byte1", 32'(b1), 32'h22);

        // WREN with trailing bits is dropped
        cs_begin();
        spi_bits(8'h06, 8, r);
        spi_bits(8'h00, 4, r);
        cs_end();
        check("wren_12clk_wel", 32'(wel), 32'h0);

        // Read aborted mid-address, then clean commands
        cs_begin();
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 4, r);
        cs_end();
        check("abort_miso", 32'(flash_miso), 32'h1);
        send_op(8'h06);
        check("abort_next_wren", 32'(wel), 32'h1);
        read_status(st);
        check("abort_rdsr", 32'(st), 32'h02);
        send_op(8'h04);
        check("wrdi_wel", 32'(wel), 32'h0);

        // Identification read
        cs_begin();
        spi_bits(8'h9F, 8, r);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'hFF, 8, r);
            id_word = {id_word[23:0], r};
        end
        cs_end();
`ifdef SPIF_RDID_EN
        id_exp = 32'hEF4015FF;
`else
        id_exp = 32'hFFFFFFFF;
`endif
        check("rdid", id_word, id_exp);
        check("final_erase_cnt", 32'(erase_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
